// File: rtl/buttons_pkg.sv
// buttons_pkg: constants and helpers shared by the debounced button input path.
//   DEBOUNCE_10MS_12MHZ : 10 ms worth of 12 MHz board-clock cycles
//   LED_W               : number of board LEDs driven by the press counter
//   cnt_width()         : debounce counter width for a given cycle count (min 1)
package buttons_pkg;

    localparam int DEBOUNCE_10MS_12MHZ = 120000;
    localparam int LED_W               = 8;

    // Wide enough to hold DEBOUNCE_CYCLES-1; a 1-cycle debounce still needs a
    // 1-bit counter so the port widths never collapse to zero.
    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/buttons_in_debounce_bit.sv
// debounce_bit: one button channel -- 2-flop synchroniser, stability counter,
// debounced level register and registered press/release pulses.
//   clk, rstn     : board clock, async active-low reset
//   din           : raw pin already normalised to pressed = 1 (asynchronous)
//   level         : debounced state, 1 = pressed
//   press_pulse   : one-cycle pulse in the cycle after level rises
//   release_pulse : one-cycle pulse in the cycle after level falls
//   toggle        : flips together with press_pulse
//   press_next    : combinational; high when press_pulse goes high at the next
//                   edge, lets the parent update counters in that same cycle
module debounce_bit
    import buttons_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic din,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic toggle,
    output logic press_next
);

    localparam int             CW      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1, s2;
    logic [CW-1:0] cnt;
    logic          level_d;
    logic          release_next;

    // Synchroniser; reset value 0 reads as "not pressed".
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
        end
    end

    // Any cycle where s2 agrees with the accepted level restarts the count, so
    // only an unbroken run of DEBOUNCE_CYCLES disagreeing cycles flips level.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (s2 == level) begin
            cnt   <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt   <= '0;
            level <= ~level;
        end else begin
            cnt   <= cnt + CW'(1);
        end
    end

    assign press_next   = level & ~level_d;
    assign release_next = ~level & level_d;

    // Edge pulses are registered from the level/level_d pair, so they trail
    // the level change by one cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            level_d       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            toggle        <= 1'b0;
        end else begin
            level_d       <= level;
            press_pulse   <= press_next;
            release_pulse <= release_next;
            toggle        <= toggle ^ press_next;
        end
    end

endmodule

// File: rtl/buttons_in_leds.sv
// buttons_leds: maps the 8-bit press counter onto the board LED pins D2..D9
// (D2 carries bit 0).
//   count  : counter value to display
//   d2..d9 : LED pin drives
module buttons_leds
    import buttons_pkg::*;
(
    input  logic [LED_W-1:0] count,
    output logic             d2,
    output logic             d3,
    output logic             d4,
    output logic             d5,
    output logic             d6,
    output logic             d7,
    output logic             d8,
    output logic             d9
);

    assign d2 = count[0];
    assign d3 = count[1];
    assign d4 = count[2];
    assign d5 = count[3];
    assign d6 = count[4];
    assign d7 = count[5];
    assign d8 = count[6];
    assign d9 = count[7];

endmodule

// File: rtl/buttons_in.sv
// buttons_in: debounced push-button block. Normalises pin polarity, runs one
// debounce_bit per input and counts accepted presses on button 0.
//   clk, rstn   : board clock, async active-low reset
//   btn_raw     : raw unsynchronised pins
//   btn_level   : debounced state, 1 = pressed
//   btn_press   : one-cycle pulse per accepted press
//   btn_release : one-cycle pulse per accepted release
//   btn_toggle  : flips on each accepted press
//   press_count : wrapping count of accepted presses on bit 0 (drives LEDs)
module buttons_in
    import buttons_pkg::*;
#(
    parameter int N               = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_12MHZ,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [N-1:0]     btn_raw,
    output logic [N-1:0]     btn_level,
    output logic [N-1:0]     btn_press,
    output logic [N-1:0]     btn_release,
    output logic [N-1:0]     btn_toggle,
    output logic [LED_W-1:0] press_count
);

    logic [N-1:0]     pressed;
    logic [N-1:0]     press_next;
    logic [LED_W-1:0] cnt;
    logic             d2, d3, d4, d5, d6, d7, d8, d9;

    assign pressed = btn_raw ^ {N{ACTIVE_LOW}};

    for (genvar i = 0; i < N; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk          (clk),
            .rstn         (rstn),
            .din          (pressed[i]),
            .level        (btn_level[i]),
            .press_pulse  (btn_press[i]),
            .release_pulse(btn_release[i]),
            .toggle       (btn_toggle[i]),
            .press_next   (press_next[i])
        );
    end

    // Advances on the same edge that raises btn_press[0].
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)              cnt <= '0;
        else if (press_next[0]) cnt <= cnt + LED_W'(1);
    end

    buttons_leds u_leds (
        .count(cnt),
        .d2(d2), .d3(d3), .d4(d4), .d5(d5),
        .d6(d6), .d7(d7), .d8(d8), .d9(d9)
    );

    assign press_count = {d9, d8, d7, d6, d5, d4, d3, d2};

endmodule

// File: tb/tb_buttons_in.sv
module tb_buttons_in;

    localparam int N  = 4;
    localparam int DC = 4;

    logic         clk = 1'b0;
    logic         rstn;
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_level, btn_press, btn_release, btn_toggle;
    logic [7:0]   press_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    buttons_in #(.N(N), .DEBOUNCE_CYCLES(DC), .ACTIVE_LOW(1'b1)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_toggle (btn_toggle),
        .press_count(press_count)
    );

    // Reference model: a level flips once the pressed-sense pin value seen
    // DC consecutive sampling edges (two edges of synchroniser delay earlier)
    // all disagree with it; pulses follow one edge after a flip.
    logic [N-1:0] hist[$];
    logic [N-1:0] m_lev, m_lev_d, m_press, m_rel, m_tog;
    logic [7:0]   m_cnt;

    function automatic void model_reset();
        m_lev = '0; m_lev_d = '0; m_press = '0; m_rel = '0; m_tog = '0; m_cnt = '0;
        hist.delete();
        for (int i = 0; i < DC + 2; i++) hist.push_back('0);
    endfunction

    function automatic void model_edge(input logic [N-1:0] p);
        logic [N-1:0] nlev;
        bit           all;
        m_press = m_lev & ~m_lev_d;
        m_rel   = ~m_lev & m_lev_d;
        m_tog   = m_tog ^ m_press;
        m_cnt   = m_cnt + {7'd0, m_press[0]};
        hist.push_back(p);
        nlev = m_lev;
        for (int b = 0; b < N; b++) begin
            all = 1'b1;
            for (int j = 2; j <= DC + 1; j++)
                if (hist[hist.size() - 1 - j][b] == m_lev[b]) all = 1'b0;
            if (all) nlev[b] = ~m_lev[b];
        end
        m_lev_d = m_lev;
        m_lev   = nlev;
        if (hist.size() > 32) void'(hist.pop_front());
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        chk("level",   32'(btn_level),   32'(m_lev));
        chk("press",   32'(btn_press),   32'(m_press));
        chk("release", 32'(btn_release), 32'(m_rel));
        chk("toggle",  32'(btn_toggle),  32'(m_tog));
        chk("count",   32'(press_count), 32'(m_cnt));
    endtask

    int press_seen[N];
    int rel_seen[N];

    // Drive raw pins, take one edge, update model, sample 1 time unit later.
    task automatic tick(input logic [N-1:0] raw);
        btn_raw = raw;
        @(posedge clk);
        if (rstn) model_edge(raw ^ {N{1'b1}});
        #1;
        compare_all();
        for (int b = 0; b < N; b++) begin
            if (btn_press[b])   press_seen[b]++;
            if (btn_release[b]) rel_seen[b]++;
        end
    endtask

    task automatic clear_seen();
        for (int b = 0; b < N; b++) begin press_seen[b] = 0; rel_seen[b] = 0; end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        model_reset();
        #1;
        compare_all();
        tick(4'hF);
        tick(4'hF);
        rstn = 1'b1;
    endtask

    logic [N-1:0] raw;

    initial begin
        btn_raw = 4'hF;
        rstn    = 1'b0;
        model_reset();
        clear_seen();
        #3;

        // 1. Reset with all pins idle (high), then 20 quiet cycles.
        do_reset();
        for (int i = 0; i < 20; i++) tick(4'hF);
        chk("reset_quiet", {btn_level, btn_press, btn_release, btn_toggle, press_count}, 32'd0);

        // 2. Clean press on bit 0: first tick is edge k.
        clear_seen();
        for (int i = 0; i < 5; i++) tick(4'hE);
        chk("clean_lvl_k4", 32'(btn_level[0]), 32'd0);
        tick(4'hE);
        chk("clean_lvl_k5", 32'(btn_level[0]), 32'd1);
        chk("clean_prs_k5", 32'(btn_press[0]), 32'd0);
        tick(4'hE);
        chk("clean_prs_k6", 32'(btn_press[0]), 32'd1);
        chk("clean_tog_k6", 32'(btn_toggle[0]), 32'd1);
        chk("clean_cnt_k6", 32'(press_count), 32'd1);
        tick(4'hE);
        chk("clean_prs_k7", 32'(btn_press[0]), 32'd0);
        for (int i = 0; i < 8; i++) tick(4'hF);

        // 3. Bounce on bit 1 never reaches acceptance, then a long hold does.
        clear_seen();
        repeat (3) tick(4'hD);
        repeat (2) tick(4'hF);
        repeat (3) tick(4'hD);
        repeat (8) tick(4'hF);
        chk("bounce_lvl", 32'(btn_level[1]), 32'd0);
        chk("bounce_prs", 32'(press_seen[1]), 32'd0);
        repeat (10) tick(4'hD);
        chk("hold_prs1", 32'(press_seen[1]), 32'd1);
        chk("hold_cnt", 32'(press_count), 32'd1);
        repeat (10) tick(4'hF);

        // 4. Press/release bit 2 twice; toggle returns to 0.
        clear_seen();
        repeat (10) tick(4'hB);
        repeat (10) tick(4'hF);
        chk("pr2_press", 32'(press_seen[2]), 32'd1);
        chk("pr2_rel", 32'(rel_seen[2]), 32'd1);
        chk("pr2_tog1", 32'(btn_toggle[2]), 32'd1);
        repeat (10) tick(4'hB);
        repeat (10) tick(4'hF);
        chk("pr2_tog0", 32'(btn_toggle[2]), 32'd0);

        // 5a. Bits 0 and 3 pressed together pulse together.
        for (int i = 0; i < 7; i++) tick(4'h6);
        chk("simul_prs", 32'(btn_press), 32'h9);
        repeat (10) tick(4'hF);

        // 5b. Wrap: 255 presses from reset, then one more.
        do_reset();
        for (int n = 0; n < 255; n++) begin
            repeat (7) tick(4'hE);
            repeat (7) tick(4'hF);
        end
        chk("wrap_255", 32'(press_count), 32'd255);
        repeat (7) tick(4'hE);
        repeat (7) tick(4'hF);
        chk("wrap_0", 32'(press_count), 32'd0);

        // 6. Reset two cycles into a count, bit 0 still held afterwards.
        tick(4'hE);
        tick(4'hE);
        rstn = 1'b0;
        model_reset();
        #1;
        chk("midrst_lvl", 32'(btn_level[0]), 32'd0);
        tick(4'hE);
        tick(4'hE);
        rstn = 1'b1;
        chk("midrst_rel_lvl", 32'(btn_level[0]), 32'd0);
        for (int i = 0; i < 5; i++) tick(4'hE);
        chk("midrst_k4", 32'(btn_level[0]), 32'd0);
        tick(4'hE);
        chk("midrst_k5", 32'(btn_level[0]), 32'd1);
        repeat (10) tick(4'hF);

        // Random bounce/hold traffic on all bits against the model.
        raw = 4'hF;
        for (int i = 0; i < 600; i++) begin
            raw = raw ^ (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
            tick(raw);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
